// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: digit codes,
// the digit-code type and the sequencing FSM state encoding.
package ssd_pkg;

    typedef logic [3:0] ssd_code_t;

    localparam ssd_code_t SSD_DASH  = 4'hA;
    localparam ssd_code_t SSD_BLANK = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FORMAT  = 2'd2
    } ssd_state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// IN_W iterations per conversion. 'last' is high in the cycle whose edge
// performs the final iteration; 'valid' is high in the cycle after it.
module bin2bcd_seq #(
    parameter int IN_W = 9,
    parameter int NIB  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IN_W-1:0]   mag,
    output logic [4*NIB-1:0]  bcd,
    output logic              valid,
    output logic              last
);

    localparam int BCD_W = 4 * NIB;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    logic [IN_W-1:0]  shift_r;
    logic [BCD_W-1:0] bcd_r;
    logic [CNT_W-1:0] cnt_r;
    logic             running_r;
    logic             valid_r;
    logic [BCD_W-1:0] adj_s;

    // Add 3 to every nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj_s = bcd_r;
        for (int n = 0; n < NIB; n++) begin
            if (bcd_r[4*n +: 4] >= 4'd5) begin
                adj_s[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
            end else begin
                adj_s[4*n +: 4] = bcd_r[4*n +: 4];
            end
        end
    end

    assign last  = running_r && (cnt_r == CNT_W'(IN_W - 1));
    assign bcd   = bcd_r;
    assign valid = valid_r;

    // Capture the magnitude on start, then shift it into the BCD accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r   <= '0;
            bcd_r     <= '0;
            cnt_r     <= '0;
            running_r <= 1'b0;
            valid_r   <= 1'b0;
        end else if (start) begin
            shift_r   <= mag;
            bcd_r     <= '0;
            cnt_r     <= '0;
            running_r <= 1'b1;
            valid_r   <= 1'b0;
        end else if (running_r) begin
            bcd_r   <= {adj_s[BCD_W-2:0], shift_r[IN_W-1]};
            shift_r <= {shift_r[IN_W-2:0], 1'b0};
            cnt_r   <= cnt_r + CNT_W'(1);
            if (last) begin
                running_r <= 1'b0;
                valid_r   <= 1'b1;
            end else begin
                valid_r   <= 1'b0;
            end
        end else begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment sequencing controller: captures an ALU result, converts it
// to BCD, formats sign/blanking/overflow into display registers and scans
// those registers onto one shared decoder with active-low digit anodes.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [WIDTH-1:0]    value,
    input  logic                is_signed,
    output logic                busy,
    output logic                done,
    output logic [3:0]          LED_BCD,
    output logic [N_DIGITS-1:0] anode
);

    localparam int MAG_W = WIDTH + 1;
    localparam int NIB   = N_DIGITS + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    ssd_state_e         state_r;
    logic               sign_r;
    logic               busy_r;
    logic               done_r;
    ssd_code_t          disp_r [N_DIGITS];
    logic [DIV_W-1:0]   div_r;
    logic [IDX_W-1:0]   idx_r;

    logic               neg_s;
    logic [MAG_W-1:0]   mag_s;
    logic               start_s;
    logic [4*NIB-1:0]   bcd_s;
    logic               bcd_valid_s;
    logic               bcd_last_s;
    ssd_code_t          fmt_s [N_DIGITS];
    logic [3:0]         guard_s;
    logic               ovf_s;
    int                 msd_s;

    // Magnitude as WIDTH+1 bits so the most negative input negates cleanly
    always_comb begin
        neg_s = is_signed & value[WIDTH-1];
        if (neg_s) begin
            mag_s = ~{value[WIDTH-1], value} + MAG_W'(1);
        end else begin
            mag_s = {1'b0, value};
        end
    end

    assign start_s = (state_r == ST_IDLE) && load;

    bin2bcd_seq #(
        .IN_W (MAG_W),
        .NIB  (NIB)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .mag   (mag_s),
        .bcd   (bcd_s),
        .valid (bcd_valid_s),
        .last  (bcd_last_s)
    );

    // Build display codes: leading blanks, sign dash, overflow dashes
    always_comb begin
        fmt_s   = '{default: SSD_BLANK};
        guard_s = bcd_s[4*N_DIGITS +: 4];
        msd_s   = 0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_s[4*i +: 4] != 4'd0) begin
                msd_s = i;
            end else begin
                msd_s = msd_s;
            end
        end
        ovf_s = (guard_s != 4'd0) ||
                (sign_r && (bcd_s[4*(N_DIGITS-1) +: 4] != 4'd0));
        for (int i = 0; i < N_DIGITS; i++) begin
            if (ovf_s) begin
                fmt_s[i] = SSD_DASH;
            end else if (i <= msd_s) begin
                fmt_s[i] = bcd_s[4*i +: 4];
            end else if (sign_r && (i == msd_s + 1)) begin
                fmt_s[i] = SSD_DASH;
            end else begin
                fmt_s[i] = SSD_BLANK;
            end
        end
    end

    // Sequencing FSM and display register commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            sign_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            disp_r  <= '{default: SSD_BLANK};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        sign_r  <= neg_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_CONVERT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    if (bcd_last_s) begin
                        state_r <= ST_FORMAT;
                    end else begin
                        state_r <= ST_CONVERT;
                    end
                end
                ST_FORMAT: begin
                    if (bcd_valid_s) begin
                        disp_r <= fmt_s;
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh divider and digit index, independent of the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
            idx_r <= '0;
        end else if (div_r == DIV_W'(CLK_DIV - 1)) begin
            div_r <= '0;
            if (idx_r == IDX_W'(N_DIGITS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign anode   = ~(N_DIGITS'(1) << idx_r);
    assign LED_BCD = disp_r[idx_r];

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Sequencing controller for the seven-segment decoder (`display_out`). It captures an ALU result, converts it from binary to decimal over several cycles, and formats it with sign, leading-zero blanking and overflow. It then time-multiplexes the digit codes onto a single shared decoder while driving the digit anodes. It sits between the n-bit ALU output and the board's decoder/anode pins.

## Interface
Parameters:
- `WIDTH`, default 8: width of the ALU result.
- `N_DIGITS`, default 4: number of display digits; digit 0 is the rightmost.
- `CLK_DIV`, default 100000: clock cycles each digit is lit; must be ≥ 2.

Ports:
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high reset.
- `load` input 1: one-cycle request to capture `value`; honoured only in IDLE.
- `value` input WIDTH: ALU result.
- `is_signed` input 1: when 1, `value` is two's complement; sampled together with `value`.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when the display registers are updated.
- `LED_BCD` output 4: digit code to the decoder.
  - 0–9: digits.
  - 4'hA: '-'.
  - 4'hB: blank.
- `anode` output N_DIGITS: active-low, one-hot digit enable.

## Operation
- FSM states: IDLE → CONVERT → FORMAT → IDLE.
- IDLE, `load`=1:
  - Latch the magnitude into a WIDTH+1-bit register. When signed and negative, the magnitude is the two's-complement negation, so the most negative value is handled.
  - Latch the sign bit (0 when unsigned).
  - Clear the BCD accumulator and go to CONVERT.
- CONVERT: double-dabble, exactly WIDTH+1 iterations, one per cycle.
  - Each iteration first adds 3 to every BCD nibble ≥ 5, then shifts left one bit.
  - The BCD accumulator has N_DIGITS nibbles plus one guard nibble.
- FORMAT (1 cycle): build the N_DIGITS display codes.
  - Leading zeros become 4'hB. A value of 0 shows only digit 0 = 0.
  - Negative: 4'hA goes in the position immediately left of the most significant non-zero digit.
  - Overflow: every digit shows 4'hA. Overflow means a non-zero guard nibble, or negative with the magnitude using all N_DIGITS digits.
  - Commit all display registers in the same cycle and pulse `done`.
- `load` while `busy`: ignored. No queueing, and the display keeps its old contents until commit.
- Scan runs continuously and independently of the FSM:
  - A refresh counter counts 0..CLK_DIV-1.
  - On wrap, the digit index advances modulo N_DIGITS: 0→1→…→N_DIGITS-1→0.
- Outputs, both combinational from registers:
  - `anode` = ~(1 << index).
  - `LED_BCD` = display register[index].
- Reset:
  - FSM goes to IDLE; `busy`=0, `done`=0.
  - All display registers = 4'hB.
  - Refresh counter = 0, index = 0, so `anode` = 1110 (for N_DIGITS=4) and `LED_BCD` = 4'hB.
  - Reset mid-conversion abandons the conversion with no `done` pulse.

## Timing
- Label cycles by clock edges, with the `load` edge as edge 0.
- `busy` is high from after edge 0 until after edge WIDTH+2.
- CONVERT occupies edges 1..WIDTH+1.
- FORMAT commit happens at edge WIDTH+2, with `done` high for the single cycle following it.
- Latency from load to display update is WIDTH+2 cycles; the next `load` is accepted at edge WIDTH+3.
- A commit takes effect on `LED_BCD` in the same cycle for whichever digit is currently selected.
- Digit dwell is exactly CLK_DIV cycles; a full refresh frame is N_DIGITS × CLK_DIV cycles.
- A commit or `load` never disturbs the counter or the index.

## Structure
- Shared package `ssd_pkg`:
  - Code constants `SSD_DASH`=4'hA and `SSD_BLANK`=4'hB.
  - Digit-code typedef (4 bits).
  - FSM state enum.
- Sub-module `bin2bcd_seq`: sequential double-dabble engine.
  - Inputs: `start`, magnitude.
  - Outputs: BCD vector, `valid`.
  - Parameterised by input width and nibble count.
- `ssd_scan_ctrl` owns the FSM, formatting, display registers and scan counter.
- `display_out` is instantiated alongside it at the top level, not inside it.

## Test plan
All scenarios use WIDTH=8, N_DIGITS=4, CLK_DIV=4 unless stated.
- Reset → `anode`=1110, `LED_BCD`=4'hB, `busy`=0, `done`=0. Then over 16 cycles the anode sequence is 1110, 1101, 1011, 0111, each held 4 cycles, then back to 1110.
- Unsigned load of 8'd42 → `busy` high for 10 cycles and `done` at edge 10. Digits 3..0 = B,B,4,2.
- Load of 8'd0 → digits B,B,B,0. Load of 8'd255 unsigned → digits B,2,5,5.
- Signed loads:
  - 8'h80 → digits A,1,2,8.
  - 8'hFF → digits B,B,A,1.
  - 8'hF6 → digits B,A,1,0.
- Load of 8'd7 asserted while `busy` from a prior load of 8'd99 → only one `done`, and the display shows 99.
- Reset asserted at edge 4 of a conversion → no `done`, digits all B, `busy`=0. A fresh load afterwards succeeds.
- With WIDTH=14, unsigned 14'd12345 → digits A,A,A,A.
